channel_noise_ctrl: RTL and testbench
=====================================

Name: channel_noise_ctrl

Overview:
- Sequencer for the 4-lane channel noise adder, which combines signal samples with noise and then truncates and saturates the result.
- Paces the adder's enable at symbol rate and joins the transmitter sample stream with the noise-generator stream using valid/ready.
- Runs frames of FRAME_LEN samples and reports per-frame status: sample count, stall cycles, overrun, saturation events.

Parameters:
FRAME_LEN, 1024, samples per frame (>=1)
DIV, 4, clocks per symbol tick (>=1; DIV=1 ticks every cycle)
CNT_W, 16, width of status counters (2^CNT_W > FRAME_LEN)

Ports:
CLK100MHZ  in  1  clock
reset  in  1  asynchronous, active-high reset
i_start  in  1  start-frame pulse; ignored unless IDLE
i_abort  in  1  abort current frame
i_sym_valid  in  1  transmitter has 4-lane sample available
o_sym_ready  out  1  sample consumed this cycle
i_noise_valid  in  1  noise generator has 4-lane noise available
o_noise_ready  out  1  noise consumed this cycle
o_ch_enable  out  1  enable to channel adder, 1-cycle pulse per sample
o_out_valid  out  1  channel outputs valid this cycle
i_sat_flags  in  4  per-lane saturation flags from channel (1i,1q,2i,2qc)
o_busy  out  1  frame in progress
o_done  out  1  1-cycle pulse at frame completion
o_sample_cnt  out  CNT_W  samples fired this frame
o_stall_cnt  out  CNT_W  cycles a tick was pending but not fired
o_sat_cnt  out  CNT_W  output samples with any lane saturated
o_overrun  out  1  sticky: new tick while previous still pending

Behaviour:
- Reset: every output and counter is 0; state IDLE; divider is 0; pending is 0.
- States: IDLE, RUN, FLUSH.
- IDLE -> RUN on i_start:
  - clears all counters, o_overrun, divider and pending;
  - o_busy is 1 from the next cycle.
- RUN:
  - Divider counts 0..DIV-1 and wraps; tick = (div==DIV-1).
  - A tick sets pending.
  - fire = RUN & (tick|pending) & i_sym_valid & i_noise_valid.
  - o_ch_enable, o_sym_ready and o_noise_ready equal fire, combinationally, in the same cycle.
  - fire clears pending and increments o_sample_cnt. A tick in the same cycle as fire is consumed by that fire.
  - Each cycle with (tick|pending) & !fire increments o_stall_cnt.
  - A tick while pending is already set and not firing sets o_overrun, which stays set until the next i_start. No pending queue depth: extra ticks are dropped.
- RUN -> FLUSH on the fire that makes o_sample_cnt reach FRAME_LEN. No further fires.
- o_out_valid is fire registered by 1 cycle, matching the adder's registered sum; it continues into FLUSH.
- FLUSH lasts 1 cycle, covering the final o_out_valid. Then o_done pulses for 1 cycle, o_busy drops in that same cycle, and the state returns to IDLE.
- o_sat_cnt increments when o_out_valid & |i_sat_flags; the counter saturates at all-ones.
- i_abort in RUN or FLUSH:
  - next state IDLE, pending cleared, no o_done pulse;
  - counters hold their values for readback;
  - a fire in the abort cycle still completes, and its o_out_valid follows.
- Priority: i_abort over everything; i_start while not IDLE is ignored; i_start and i_abort together in IDLE means stay IDLE.
- Reset asserted mid-frame returns immediately to the reset values.

Optional Feature:
- Macro: CHCTRL_SAT_CNT_EN.
- Defined: o_sat_cnt behaves as specified and i_sat_flags is used.
- Undefined: the saturation counter logic is omitted, o_sat_cnt is tied to 0 and i_sat_flags is ignored.

Test Plan:
- FRAME_LEN=8, DIV=4, both valids held 1, pulse i_start:
  - 8 o_ch_enable pulses spaced 4 cycles apart;
  - o_out_valid each 1 cycle later;
  - o_done 2 cycles after the last fire;
  - o_sample_cnt=8, o_stall_cnt=0, o_overrun=0.
- Same setup, i_noise_valid low for 2 cycles spanning the 3rd tick: that fire is delayed 2 cycles, o_stall_cnt=2, o_overrun=0, later fires stay on the tick grid.
- i_sym_valid low for 6 cycles covering 2 ticks: o_overrun=1 and stays set through o_done; one tick is lost, so frame completion takes 4 cycles longer.
- With the macro defined, i_sat_flags=4'b0100 on 3 o_out_valid cycles and 0 otherwise: o_sat_cnt=3. Macro undefined: o_sat_cnt=0.
- i_abort after 5 fires: next cycle IDLE, o_busy=0, no o_done, o_sample_cnt holds 5. i_start then clears the counters and runs a full 8-sample frame.
- i_start pulsed mid-frame is ignored (counts unaffected). reset asserted mid-frame forces all outputs to 0 on the same edge.

Source files
------------

// File: rtl/channel_noise_ctrl_if.sv
// Sample/noise stream handshake and channel adder strobes for channel_noise_ctrl.
// Signals:
//   i_sym_valid / o_sym_ready     - transmitter 4-lane sample stream
//   i_noise_valid / o_noise_ready - noise generator 4-lane stream
//   o_ch_enable                   - per-sample enable to the channel adder
//   o_out_valid                   - adder output valid (fire delayed by one cycle)
//   i_sat_flags                   - per-lane saturation flags from the adder
// Modports: master = stream source / adder side, slave = sequencer.
interface channel_noise_ctrl_if;
    logic       i_sym_valid;
    logic       o_sym_ready;
    logic       i_noise_valid;
    logic       o_noise_ready;
    logic       o_ch_enable;
    logic       o_out_valid;
    logic [3:0] i_sat_flags;

    modport master (
        output i_sym_valid, i_noise_valid, i_sat_flags,
        input  o_sym_ready, o_noise_ready, o_ch_enable, o_out_valid
    );

    modport slave (
        input  i_sym_valid, i_noise_valid, i_sat_flags,
        output o_sym_ready, o_noise_ready, o_ch_enable, o_out_valid
    );
endinterface

// File: rtl/channel_noise_ctrl.sv
// Sequencer for the 4-lane channel noise adder: paces the adder enable at
// symbol rate, joins the sample and noise streams, runs FRAME_LEN-sample
// frames and keeps per-frame status counters.
// Ports:
//   CLK100MHZ, reset (async, active-high)
//   i_start, i_abort       - frame control
//   stream                 - channel_noise_ctrl_if.slave handshake bundle
//   o_busy, o_done         - frame in progress / completion pulse
//   o_sample_cnt, o_stall_cnt, o_sat_cnt, o_overrun - frame status
// Optional macro CHCTRL_SAT_CNT_EN: when defined, o_sat_cnt counts adder
// outputs with any lane saturated; otherwise it is tied to 0.
module channel_noise_ctrl #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned DIV       = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    channel_noise_ctrl_if.slave  stream,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_sample_cnt,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_sat_cnt,
    output logic                 o_overrun
);

    localparam int unsigned       DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] div_q;
    logic             pending_q;
    logic             out_valid_q;
    logic             tick;
    logic             fire;
    logic             clear;
    logic             done_d;

    // State register
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, tick/fire decode and frame-start clear
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        done_d  = 1'b0;
        tick    = (state_q == ST_RUN) && (div_q == DIV_LAST);
        fire    = (state_q == ST_RUN) && (tick || pending_q) &&
                  stream.i_sym_valid && stream.i_noise_valid;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (fire && (o_sample_cnt == LAST_CNT)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                done_d  = !i_abort;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divider, pending tick and frame status counters
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            out_valid_q  <= 1'b0;
            div_q        <= '0;
            pending_q    <= 1'b0;
            o_sample_cnt <= '0;
            o_stall_cnt  <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_busy      <= (state_d != ST_IDLE);
            o_done      <= done_d;
            out_valid_q <= fire;
            if (clear) begin
                div_q        <= '0;
                pending_q    <= 1'b0;
                o_sample_cnt <= '0;
                o_stall_cnt  <= '0;
                o_overrun    <= 1'b0;
            end else if (state_q == ST_RUN) begin
                div_q <= tick ? '0 : div_q + DIV_W'(1);
                // A fire consumes both the pending tick and any same-cycle tick
                if (fire || i_abort) begin
                    pending_q <= 1'b0;
                end else if (tick) begin
                    pending_q <= 1'b1;
                end
                if (fire) begin
                    o_sample_cnt <= o_sample_cnt + CNT_W'(1);
                end
                if ((tick || pending_q) && !fire) begin
                    o_stall_cnt <= o_stall_cnt + CNT_W'(1);
                end
                // Only one tick can wait; a second one is dropped and flagged
                if (tick && pending_q && !fire) begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef CHCTRL_SAT_CNT_EN
    // Saturating count of adder outputs with any lane clipped
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            o_sat_cnt <= '0;
        end else if (clear) begin
            o_sat_cnt <= '0;
        end else if (out_valid_q && (|stream.i_sat_flags) && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_sat_flags;
    assign unused_sat_flags = ^stream.i_sat_flags;
    assign o_sat_cnt        = '0;
`endif

    // Handshake strobes are the same-cycle fire decision
    assign stream.o_ch_enable   = fire;
    assign stream.o_sym_ready   = fire;
    assign stream.o_noise_ready = fire;
    assign stream.o_out_valid   = out_valid_q;

endmodule

// File: tb/tb_channel_noise_ctrl.sv
// Directed bench for channel_noise_ctrl with FRAME_LEN=8, DIV=4.
// Timing is recorded relative to the first RUN cycle of each frame.
module tb_channel_noise_ctrl;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned DIV       = 4;
    localparam int unsigned CNT_W     = 16;
`ifdef CHCTRL_SAT_CNT_EN
    localparam int SAT_EXP = 3;
`else
    localparam int SAT_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_abort;
    logic             o_busy;
    logic             o_done;
    logic             o_overrun;
    logic [CNT_W-1:0] o_sample_cnt;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_sat_cnt;

    channel_noise_ctrl_if bus ();

    channel_noise_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .DIV       (DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .stream       (bus),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sample_cnt (o_sample_cnt),
        .o_stall_cnt  (o_stall_cnt),
        .o_sat_cnt    (o_sat_cnt),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int en_q[$];
    int ov_q[$];
    int exp_en[$];
    int done_c;
    int exit_rel;
    int s;
    int timed_out;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle stimulus for each scenario at relative cycle r
    task automatic drive(input int mode, input int r);
        bus.i_sym_valid   = !(mode == 3 && r >= 10 && r <= 15);
        bus.i_noise_valid = !(mode == 2 && (r == 11 || r == 12));
        bus.i_sat_flags   = (mode == 4 && (r == 4 || r == 5 || r == 8 || r == 12)) ?
                            4'b0100 : 4'b0000;
        i_abort = (mode == 5 && r == 19);
        i_start = (mode == 6 && r == 10);
        if (mode == 7 && r == 14) reset = 1'b1;
    endtask

    // Pulse start, then run until o_busy drops (bounded)
    task automatic run_frame(input int mode);
        en_q.delete();
        ov_q.delete();
        done_c    = -1;
        exit_rel  = -1;
        timed_out = 1;
        @(posedge clk); #1;
        drive(0, -1);
        i_start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        for (int k = 0; k < 80; k++) begin
            drive(mode, cyc - s);
            @(negedge clk);
            if (bus.o_ch_enable) en_q.push_back(cyc - s);
            if (bus.o_out_valid) ov_q.push_back(cyc - s);
            if (o_done) done_c = cyc - s;
            if (!o_busy) begin
                exit_rel  = cyc - s;
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        check("frame_timeout", timed_out, 0);
    endtask

    task automatic check_grid(input string tag);
        check({tag, "_n_en"}, en_q.size(), exp_en.size());
        check({tag, "_n_ov"}, ov_q.size(), exp_en.size());
        for (int k = 0; k < exp_en.size(); k++) begin
            if (k < en_q.size()) check({tag, "_en"}, en_q[k], exp_en[k]);
            if (k < ov_q.size()) check({tag, "_ov"}, ov_q[k], exp_en[k] + 1);
        end
    endtask

    task automatic base_grid();
        exp_en.delete();
        for (int k = 0; k < 8; k++) exp_en.push_back(3 + 4 * k);
    endtask

    task automatic check_status(input string tag, input int smp, input int stl,
                                input int ovr, input int sat, input int dn);
        check({tag, "_sample"},  int'(o_sample_cnt), smp);
        check({tag, "_stall"},   int'(o_stall_cnt), stl);
        check({tag, "_overrun"}, int'(o_overrun), ovr);
        check({tag, "_sat"},     int'(o_sat_cnt), sat);
        check({tag, "_done"},    done_c, dn);
    endtask

    initial begin
        int dn;
        reset             = 1'b1;
        i_start           = 1'b0;
        i_abort           = 1'b0;
        bus.i_sym_valid   = 1'b0;
        bus.i_noise_valid = 1'b0;
        bus.i_sat_flags   = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_busy",    int'(o_busy), 0);
        check("rst_done",    int'(o_done), 0);
        check("rst_sample",  int'(o_sample_cnt), 0);
        check("rst_stall",   int'(o_stall_cnt), 0);
        check("rst_sat",     int'(o_sat_cnt), 0);
        check("rst_overrun", int'(o_overrun), 0);
        check("rst_en",      int'(bus.o_ch_enable), 0);
        check("rst_ov",      int'(bus.o_out_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Clean frame on the tick grid
        run_frame(0);
        base_grid();
        check_grid("t1");
        check_status("t1", 8, 0, 0, 0, 33);

        // Noise gap over the third tick delays that fire by two cycles
        run_frame(2);
        base_grid();
        exp_en[2] = 13;
        check_grid("t2");
        check_status("t2", 8, 2, 0, 0, 33);

        // Sample gap over two ticks: overrun, one tick lost
        run_frame(3);
        base_grid();
        exp_en[2] = 16;
        for (int k = 3; k < 8; k++) exp_en[k] = 4 * k + 7;
        check_grid("t3");
        check_status("t3", 8, 5, 1, 0, 37);
        repeat (3) @(negedge clk);
        check("t3_overrun_sticky", int'(o_overrun), 1);

        // Saturation flags on three output-valid cycles plus one idle cycle
        run_frame(4);
        base_grid();
        check_grid("t4");
        check_status("t4", 8, 0, 0, SAT_EXP, 33);

        // Abort coinciding with the fifth fire
        run_frame(5);
        exp_en.delete();
        for (int k = 0; k < 5; k++) exp_en.push_back(3 + 4 * k);
        check_grid("t5");
        check("t5_exit", exit_rel, 20);
        check("t5_ov_at_exit", int'(bus.o_out_valid), 1);
        check_status("t5", 5, 0, 0, 0, -1);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done) dn++;
        end
        check("t5_no_done", dn, 0);
        check("t5_hold_sample", int'(o_sample_cnt), 5);

        // Restart after abort clears counters
        run_frame(0);
        base_grid();
        check_grid("t5r");
        check_status("t5r", 8, 0, 0, 0, 33);

        // Start pulse mid-frame is ignored
        run_frame(6);
        base_grid();
        check_grid("t6");
        check_status("t6", 8, 0, 0, 0, 33);

        // Reset mid-frame
        run_frame(7);
        check("t7_exit", exit_rel, 14);
        check("t7_n_en", en_q.size(), 3);
        check("t7_busy", int'(o_busy), 0);
        check("t7_sample", int'(o_sample_cnt), 0);
        check("t7_en", int'(bus.o_ch_enable), 0);
        check("t7_ov", int'(bus.o_out_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t7_idle_busy", int'(o_busy), 0);

        // Recovery after reset
        run_frame(0);
        base_grid();
        check_grid("t8");
        check_status("t8", 8, 0, 0, 0, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
